// File: rtl/cc_hit_miss_router.sv
// Hit/miss router between tag compare and the reorder unit: pushes ordering flags and hit lines, issues miss bursts.
// Optional hit/miss statistics counters are enabled by defining CC_ROUTER_STATS_EN.
`timescale 1ns/1ps

module cc_hit_miss_router_chk (
   input logic       clk,
   input logic       rst_n,
   input logic [3:0] outstanding,
   input logic       ar_hs,
   input logic       rlast_hs
);
   // A final beat with nothing outstanding means the memory side broke the protocol.
   no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rlast_hs && !ar_hs && (outstanding == 4'd0)));
endmodule

module cc_hit_miss_router #(
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  lookup_valid_i,
   output logic                  lookup_ready_o,
   input  logic                  lookup_hit_i,
   input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
   input  logic [511:0]          lookup_data_i,
   input  logic                  hit_flag_fifo_afull_i,
   output logic                  hit_flag_fifo_wren_o,
   output logic                  hit_flag_fifo_wdata_o,
   input  logic                  hit_data_fifo_afull_i,
   output logic                  hit_data_fifo_wren_o,
   output logic [517:0]          hit_data_fifo_wdata_o,
   output logic [ADDR_WIDTH-1:0] mem_araddr_o,
   output logic [3:0]            mem_arlen_o,
   output logic [2:0]            mem_arsize_o,
   output logic [1:0]            mem_arburst_o,
   output logic                  mem_arvalid_o,
   input  logic                  mem_arready_i,
`ifdef CC_ROUTER_STATS_EN
   output logic [31:0]           stat_hit_cnt_o,
   output logic [31:0]           stat_miss_cnt_o,
`endif
   input  logic                  mem_rvalid_i,
   input  logic                  mem_rready_i,
   input  logic                  mem_rlast_i
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_AR_REQ = 1'b1} state_t;

   localparam logic [3:0] MAX_OUT = MAX_OUTSTANDING[3:0];

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [3:0]              outstanding_r;
   logic                    accept_s;
   logic                    hit_accept_s;
   logic                    miss_accept_s;
   logic                    ar_hs_s;
   logic                    rlast_hs_s;
   logic                    flag_wren_r;
   logic                    flag_wdata_r;
   logic                    data_wren_r;
   logic [517:0]            data_wdata_r;
   logic [ADDR_WIDTH-1:0]   araddr_r;

   // Acceptance: flag slot always needed; hits need a data slot, misses need a free AR slot.
   always_comb begin
      lookup_ready_o = 1'b0;
      if (!rst_n || hit_flag_fifo_afull_i) begin
         lookup_ready_o = 1'b0;
      end else if (lookup_hit_i) begin
         lookup_ready_o = !hit_data_fifo_afull_i;
      end else begin
         lookup_ready_o = (state_r == ST_IDLE) && (outstanding_r < MAX_OUT);
      end
   end

   assign accept_s      = lookup_valid_i && lookup_ready_o;
   assign hit_accept_s  = accept_s && lookup_hit_i;
   assign miss_accept_s = accept_s && !lookup_hit_i;
   assign ar_hs_s       = (state_r == ST_AR_REQ) && mem_arready_i;
   assign rlast_hs_s    = mem_rvalid_i && mem_rready_i && mem_rlast_i;

   // AR request next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (miss_accept_s) begin
               state_nxt_s = ST_AR_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_AR_REQ: begin
            if (mem_arready_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_AR_REQ;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // AR state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Outstanding-miss counter; a simultaneous issue and retire cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_r <= 4'd0;
      end else begin
         case ({ar_hs_s, rlast_hs_s})
            2'b10:   outstanding_r <= outstanding_r + 4'd1;
            2'b01:   outstanding_r <= (outstanding_r == 4'd0) ? 4'd0 : outstanding_r - 4'd1;
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   // Registered FIFO pushes and captured AR address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_wren_r  <= 1'b0;
         flag_wdata_r <= 1'b0;
         data_wren_r  <= 1'b0;
         data_wdata_r <= 518'd0;
         araddr_r     <= {ADDR_WIDTH{1'b0}};
      end else begin
         flag_wren_r <= accept_s;
         data_wren_r <= hit_accept_s;
         if (accept_s) begin
            flag_wdata_r <= lookup_hit_i;
         end
         if (hit_accept_s) begin
            data_wdata_r <= {lookup_addr_i[5:0], lookup_data_i};
         end
         if (miss_accept_s) begin
            araddr_r <= {lookup_addr_i[ADDR_WIDTH-1:3], 3'b000};
         end
      end
   end

   assign hit_flag_fifo_wren_o  = flag_wren_r;
   assign hit_flag_fifo_wdata_o = flag_wdata_r;
   assign hit_data_fifo_wren_o  = data_wren_r;
   assign hit_data_fifo_wdata_o = data_wdata_r;
   assign mem_araddr_o          = araddr_r;
   assign mem_arvalid_o         = (state_r == ST_AR_REQ);
   assign mem_arlen_o           = 4'd7;
   assign mem_arsize_o          = 3'b011;
   assign mem_arburst_o         = 2'b10;

`ifdef CC_ROUTER_STATS_EN
   logic [31:0] stat_hit_r;
   logic [31:0] stat_miss_r;

   // Saturating accept statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hit_r  <= 32'd0;
         stat_miss_r <= 32'd0;
      end else begin
         if (hit_accept_s && (stat_hit_r != 32'hFFFF_FFFF)) begin
            stat_hit_r <= stat_hit_r + 32'd1;
         end
         if (miss_accept_s && (stat_miss_r != 32'hFFFF_FFFF)) begin
            stat_miss_r <= stat_miss_r + 32'd1;
         end
      end
   end

   assign stat_hit_cnt_o  = stat_hit_r;
   assign stat_miss_cnt_o = stat_miss_r;
`endif

   cc_hit_miss_router_chk u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .outstanding (outstanding_r),
      .ar_hs       (ar_hs_s),
      .rlast_hs    (rlast_hs_s)
   );

endmodule

// File: doc/cc_hit_miss_router.md
Name: cc_hit_miss_router

Overview:
- Sits directly upstream of the cache controller's data reorder unit, between the tag-compare lookup stage and the reorder unit's hit-flag and hit-data FIFOs.
- Per accepted lookup, pushes one ordering flag: 1 for a hit, 0 for a miss.
- A hit also pushes the 512-bit line plus its 6-bit byte offset into the hit-data FIFO.
- A miss issues one 8-beat AXI wrap read burst to memory, critical word first, and tracks outstanding misses until each burst's rlast.

Parameters:
- ADDR_WIDTH, 32, request/AR address width.
- MAX_OUTSTANDING, 4, maximum misses with AR issued but rlast not yet returned; must be 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assert, active-low
- lookup_valid_i  input  1  lookup result valid
- lookup_ready_o  output  1  lookup result accepted when valid&&ready
- lookup_hit_i  input  1  1=hit, 0=miss
- lookup_addr_i  input  ADDR_WIDTH  request byte address
- lookup_data_i  input  512  cache line (valid when hit)
- hit_flag_fifo_afull_i  input  1  flag FIFO almost full
- hit_flag_fifo_wren_o  output  1  flag FIFO write
- hit_flag_fifo_wdata_o  output  1  flag: 1=hit, 0=miss
- hit_data_fifo_afull_i  input  1  data FIFO almost full
- hit_data_fifo_wren_o  output  1  data FIFO write
- hit_data_fifo_wdata_o  output  518  {addr[5:0], line[511:0]}
- mem_araddr_o  output  ADDR_WIDTH  AR address
- mem_arlen_o  output  4  fixed 4'd7
- mem_arsize_o  output  3  fixed 3'b011
- mem_arburst_o  output  2  fixed 2'b10 (WRAP)
- mem_arvalid_o  output  1  AR valid
- mem_arready_i  input  1  AR ready
- mem_rvalid_i  input  1  R valid (monitor only)
- mem_rready_i  input  1  R ready as driven by reorder unit (monitor only)
- mem_rlast_i  input  1  R last (monitor only)

Behaviour:
- Reset: all wren outputs, mem_arvalid_o and lookup_ready_o are 0. wdata and araddr registers are 0. State is IDLE and the outstanding counter is 0.
- lookup_ready_o is combinational:
  - Requires !hit_flag_fifo_afull_i.
  - Hit: additionally requires !hit_data_fifo_afull_i.
  - Miss: additionally requires state==IDLE and outstanding<MAX_OUTSTANDING.
  - Ready may depend on lookup_hit_i. The source must hold all lookup fields stable while valid&&!ready.
- FIFO writes are registered. A lookup accepted in cycle N produces its flag write (and data write, for a hit) in cycle N+1. Each write is a single-cycle pulse. Back-to-back accepts give back-to-back writes.
- Afull thresholds must tolerate one write in flight. Bench FIFO configuration: flag depth 4 / afull 2, data depth 2 / afull 1.
- The order of flag pushes equals lookup accept order, for hits and misses alike.
- AR state machine:
  - IDLE: a miss accepted moves to AR_REQ next cycle.
  - AR_REQ: mem_araddr_o = {addr[ADDR_WIDTH-1:3], 3'b000} and mem_arvalid_o=1. Address and valid stay stable until arready.
  - AR_REQ with arvalid&&arready: return to IDLE next cycle; outstanding +1.
- Hits continue to be accepted while in AR_REQ. A second miss stalls until IDLE.
- Outstanding counter:
  - Increment on AR handshake.
  - Decrement on mem_rvalid_i&&mem_rready_i&&mem_rlast_i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 is impossible by protocol; flag a simulation assertion, counter holds 0.
- At outstanding==MAX_OUTSTANDING, misses stall and hits continue.
- Reset asserted mid-burst or mid-AR: immediate return to reset values. No pending AR survives.

Optional Feature:
- Macro CC_ROUTER_STATS_EN.
- When defined, adds outputs stat_hit_cnt_o[31:0] and stat_miss_cnt_o[31:0]:
  - Each increments on an accepted hit or miss respectively.
  - Each saturates at 32'hFFFF_FFFF.
  - Both reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single hit, addr=0x1000_0028, data=pattern P:
  - Cycle N+1: flag wren with wdata=1.
  - Data wren with wdata={6'h28,P}.
  - No arvalid.
- Single miss, addr=0x2000_003C, arready held 0 for 3 cycles:
  - Flag wdata=0 at N+1.
  - araddr=0x2000_0038, arlen=7, arburst=2 stable for 3 cycles.
  - Outstanding=1 after handshake.
- Sequence hit, miss, hit, miss with arready low:
  - Flags 1,0,1 pushed in order.
  - The second miss holds lookup_ready_o=0 until AR completes.
- MAX_OUTSTANDING=4, five misses, no rlast:
  - The fifth miss stalls with lookup_ready_o=0.
  - One rlast handshake releases it.
  - AR handshake and rlast handshake in the same cycle keep the count unchanged.
- hit_data_fifo_afull_i=1 with a hit pending: ready=0. A miss presented instead is accepted.
- Reset asserted while arvalid=1: arvalid drops asynchronously and the counter reads 0 after release.
